// File: rtl/i2c_master_tx.sv
// Single-byte I2C write master: START, 7-bit address + W, ACK, one data byte, ACK, STOP.
// SCL is push-pull, SDA is open drain; all bus timing comes from CLK_DIV clk cycles per quarter bit.
module i2c_master_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl,
    inout  wire        sda,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        ACK1  = 3'd3,
        DATA  = 3'd4,
        ACK2  = 3'd5,
        STOP  = 3'd6
    } state_e;

    state_e     state_q;
    logic [7:0] div_q;
    logic [1:0] qtr_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       busy_q;
    logic       done_q;
    logic       ack_error_q;
    logic       scl_q;
    logic       sda_low_q;
    logic       ack_q;
    logic       tick;

    assign tick = busy_q && (div_q == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            qtr_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_error_q <= 1'b0;
            scl_q       <= 1'b1;
            sda_low_q   <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q || tick) div_q <= '0;
            else                 div_q <= div_q + 8'd1;

            if (state_q == IDLE) begin
                // A start in the done cycle is dropped so the earliest restart is one clk later.
                if (start && !done_q) begin
                    shift_q     <= {slave_addr, 1'b0};
                    data_q      <= tx_data;
                    ack_error_q <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= START;
                    sda_low_q   <= 1'b1;
                    scl_q       <= 1'b1;
                    qtr_q       <= '0;
                    bit_q       <= '0;
                end
            end else if (tick) begin
                qtr_q <= qtr_q + 2'd1;
                if (state_q == START) begin
                    if (qtr_q == 2'd1) begin
                        state_q   <= ADDR;
                        qtr_q     <= '0;
                        scl_q     <= 1'b0;
                        sda_low_q <= ~shift_q[7];
                    end
                end else begin
                    // End of Q1: SCL rises; the pre-edge SDA is the ACK sample (undriven or unknown is NACK).
                    if (qtr_q == 2'd1) begin
                        scl_q <= 1'b1;
                        ack_q <= (sda === 1'b0);
                    end
                    if (qtr_q == 2'd2 && state_q == STOP) sda_low_q <= 1'b0;
                    if (qtr_q == 2'd3) begin
                        scl_q <= 1'b0;
                        bit_q <= bit_q + 3'd1;
                        case (state_q)
                            ADDR, DATA: begin
                                if (bit_q == 3'd7) begin
                                    state_q   <= (state_q == ADDR) ? ACK1 : ACK2;
                                    sda_low_q <= 1'b0;
                                end else begin
                                    shift_q   <= {shift_q[6:0], 1'b0};
                                    sda_low_q <= ~shift_q[6];
                                end
                            end
                            ACK1: begin
                                if (ack_q) begin
                                    state_q   <= DATA;
                                    bit_q     <= '0;
                                    shift_q   <= data_q;
                                    sda_low_q <= ~data_q[7];
                                end else begin
                                    ack_error_q <= 1'b1;
                                    state_q     <= STOP;
                                    sda_low_q   <= 1'b1;
                                end
                            end
                            ACK2: begin
                                if (!ack_q) ack_error_q <= 1'b1;
                                state_q   <= STOP;
                                sda_low_q <= 1'b1;
                            end
                            STOP: begin
                                scl_q   <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign sda       = sda_low_q ? 1'b0 : 1'bz;
    assign scl       = scl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: pulled-up open-drain bus, an ACKing slave at 0x50, and a
// protocol-level model of the bit sequence seen on SCL rises plus transfer latency.
module tb_i2c_master_tx;

    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] SLV_ADDR = 7'h50;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] slave_addr;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       ack_error;
    logic       scl;
    logic [2:0] state;
    wire        sda;
    logic       slave_drive = 1'b0;
    logic       data_ack_en;

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = slave_drive ? 1'b0 : 1'bz;

    i2c_master_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .slave_addr (slave_addr),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .ack_error  (ack_error),
        .scl        (scl),
        .sda        (sda),
        .state      (state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus monitor + slave model ----------------
    logic [0:0] obs_q[$];
    int         rise_cnt  = 0;
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         done_cnt  = 0;
    logic       scl_prev  = 1'b1;
    logic       sda_prev  = 1'b1;
    logic [7:0] rx_addr   = '0;
    logic [7:0] rx_data   = '0;

    always @(negedge clk) begin : monitor
        logic c;
        logic s;
        c = scl;
        s = sda;
        if (reset) begin
            slave_drive = 1'b0;
            rise_cnt    = 0;
            scl_prev    = 1'b1;
            sda_prev    = 1'b1;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (c && scl_prev) begin
                if (sda_prev && !s) begin
                    start_cnt++;
                    rise_cnt = 0;
                end
                if (!sda_prev && s) stop_cnt++;
            end
            if (c && !scl_prev) begin
                obs_q.push_back(s);
                rise_cnt++;
                if (rise_cnt <= 8)                       rx_addr = {rx_addr[6:0], s};
                else if (rise_cnt >= 10 && rise_cnt <= 17) rx_data = {rx_data[6:0], s};
            end
            if (!c && scl_prev) begin
                if (rise_cnt == 8)       slave_drive = (rx_addr[7:1] == SLV_ADDR) && !rx_addr[0];
                else if (rise_cnt == 17) slave_drive = data_ack_en;
                else                     slave_drive = 1'b0;
            end
            scl_prev = c;
            sda_prev = s;
        end
    end

    // ---------------- reference model ----------------
    logic [0:0] exp_q[$];
    int acc_cyc;
    int obs_base;
    int start_base;
    int stop_base;
    int done_base;

    // Bits on each SCL rise: address+W, ACK bit, then (if addressed) data and its ACK,
    // and finally the STOP clock rise with SDA still low.
    task automatic model_bus(input logic [6:0] a, input logic [7:0] d, input bit dack);
        logic [7:0] ab;
        ab = {a, 1'b0};
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
        if (a != SLV_ADDR) begin
            exp_q.push_back(1'b1);
        end else begin
            exp_q.push_back(1'b0);
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
            exp_q.push_back(dack ? 1'b0 : 1'b1);
        end
        exp_q.push_back(1'b0);
    endtask

    function automatic int exp_clks(input logic [6:0] a);
        return ((a == SLV_ADDR) ? (2 + 72 + 4) : (2 + 36 + 4)) * CLK_DIV;
    endfunction

    function automatic int bus_diff();
        int n;
        int len;
        len = obs_q.size() - obs_base;
        n = (len > exp_q.size()) ? len - exp_q.size() : exp_q.size() - len;
        for (int i = 0; i < len && i < exp_q.size(); i++)
            if (obs_q[obs_base + i] !== exp_q[i]) n++;
        return n;
    endfunction

    // ---------------- drivers ----------------
    task automatic launch(input logic [6:0] a, input logic [7:0] d, input bit dack);
        int guard;
        guard = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        obs_base   = obs_q.size();
        start_base = start_cnt;
        stop_base  = stop_cnt;
        done_base  = done_cnt;
        slave_addr = a;
        tx_data    = d;
        data_ack_en = dack;
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        acc_cyc = cyc;
        model_bus(a, d, dack);
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b expected 1", scl); end
        n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        n_tests++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL reset_ack_error: got %b expected 0", ack_error); end
        n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (state !== 3'd0 || busy !== 1'b0 || scl !== 1'b1) begin
            n_fail++; $display("FAIL idle_after_reset: state %0d busy %b scl %b expected 0 0 1", state, busy, scl);
        end
    endtask

    task automatic test_write_ack();
        logic [7:0] d;
        int dcyc;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            launch(SLV_ADDR, d, 1'b1);
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_ack_busy: got %b expected 1", busy); end
            slave_addr = 7'($urandom);
            tx_data    = 8'($urandom);
            wait_done(dcyc);
            n_tests++; if (dcyc < 0 || dcyc - acc_cyc !== exp_clks(SLV_ADDR)) begin
                n_fail++; $display("FAIL write_ack_latency: got %0d expected %0d", dcyc - acc_cyc, exp_clks(SLV_ADDR));
            end
            n_tests++; if (ack_error !== 1'b0) begin n_fail++; $display("FAIL write_ack_err: got %b expected 0", ack_error); end
            n_tests++; if (bus_diff() !== 0) begin
                n_fail++; $display("FAIL write_ack_bits: %0d bit errors, got %0d rises expected %0d", bus_diff(), obs_q.size() - obs_base, exp_q.size());
            end
            n_tests++; if (start_cnt - start_base !== 1 || stop_cnt - stop_base !== 1) begin
                n_fail++; $display("FAIL write_ack_start_stop: got %0d/%0d expected 1/1", start_cnt - start_base, stop_cnt - stop_base);
            end
            n_tests++; if (rx_data !== d) begin n_fail++; $display("FAIL write_ack_rx: got %h expected %h", rx_data, d); end
            @(negedge clk);
            n_tests++; if (done !== 1'b0 || scl !== 1'b1 || sda !== 1'b1) begin
                n_fail++; $display("FAIL write_ack_idle: done %b scl %b sda %b expected 0 1 1", done, scl, sda);
            end
        end
    endtask

    task automatic test_addr_nack();
        logic [6:0] a;
        int dcyc;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 7'h51 : 7'($urandom_range(0, 127));
            if (a == SLV_ADDR) a = 7'h51;
            launch(a, 8'($urandom), 1'b1);
            wait_done(dcyc);
            n_tests++; if (dcyc < 0 || dcyc - acc_cyc !== exp_clks(a)) begin
                n_fail++; $display("FAIL addr_nack_latency: got %0d expected %0d", dcyc - acc_cyc, exp_clks(a));
            end
            n_tests++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL addr_nack_err: got %b expected 1", ack_error); end
            n_tests++; if (bus_diff() !== 0) begin
                n_fail++; $display("FAIL addr_nack_bits: %0d bit errors, got %0d rises expected %0d", bus_diff(), obs_q.size() - obs_base, exp_q.size());
            end
            n_tests++; if (stop_cnt - stop_base !== 1) begin n_fail++; $display("FAIL addr_nack_stop: got %0d expected 1", stop_cnt - stop_base); end
        end
    endtask

    task automatic test_data_nack();
        logic [7:0] d;
        int dcyc;
        for (int it = 0; it < 2; it++) begin
            d = 8'($urandom_range(0, 255));
            launch(SLV_ADDR, d, 1'b0);
            wait_done(dcyc);
            n_tests++; if (dcyc < 0 || dcyc - acc_cyc !== exp_clks(SLV_ADDR)) begin
                n_fail++; $display("FAIL data_nack_latency: got %0d expected %0d", dcyc - acc_cyc, exp_clks(SLV_ADDR));
            end
            n_tests++; if (ack_error !== 1'b1) begin n_fail++; $display("FAIL data_nack_err: got %b expected 1", ack_error); end
            n_tests++; if (bus_diff() !== 0 || stop_cnt - stop_base !== 1) begin
                n_fail++; $display("FAIL data_nack_bus: %0d bit errors, stops %0d expected 0 errors 1 stop", bus_diff(), stop_cnt - stop_base);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1;
        logic [7:0] d2;
        int dcyc;
        int m;
        d1 = 8'($urandom_range(0, 255));
        d2 = 8'($urandom_range(0, 255));
        launch(SLV_ADDR, d1, 1'b1);
        repeat (99) @(negedge clk);
        slave_addr = 7'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        slave_addr = SLV_ADDR;
        tx_data    = d2;
        start      = 1'b1;
        wait_done(dcyc);
        m = dcyc;
        n_tests++; if (dcyc < 0 || dcyc - acc_cyc !== exp_clks(SLV_ADDR)) begin
            n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", dcyc - acc_cyc, exp_clks(SLV_ADDR));
        end
        n_tests++; if (bus_diff() !== 0) begin n_fail++; $display("FAIL b2b_first_bits: %0d bit errors expected 0", bus_diff()); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || done_cnt - done_base !== 1) begin
            n_fail++; $display("FAIL b2b_done_cycle: busy %b dones %0d expected 0 and 1", busy, done_cnt - done_base);
        end
        obs_base   = obs_q.size();
        start_base = start_cnt;
        stop_base  = stop_cnt;
        @(negedge clk);
        n_tests++; if (busy !== 1'b1 || cyc !== m + 2) begin
            n_fail++; $display("FAIL b2b_reaccept: busy %b at +%0d expected 1 at +2", busy, cyc - m);
        end
        start   = 1'b0;
        acc_cyc = m + 2;
        model_bus(SLV_ADDR, d2, 1'b1);
        wait_done(dcyc);
        n_tests++; if (dcyc < 0 || dcyc - acc_cyc !== exp_clks(SLV_ADDR)) begin
            n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", dcyc - acc_cyc, exp_clks(SLV_ADDR));
        end
        n_tests++; if (bus_diff() !== 0 || rx_data !== d2) begin
            n_fail++; $display("FAIL b2b_second_bits: %0d bit errors, rx %h expected 0 errors rx %h", bus_diff(), rx_data, d2);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int dcyc;
        launch(SLV_ADDR, 8'($urandom_range(0, 255)), 1'b1);
        guard = 0;
        while (state !== 3'd4 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        n_tests++; if (state !== 3'd4) begin n_fail++; $display("FAIL reset_mid_reach_data: state %0d expected 4", state); end
        repeat (3 * 4 * CLK_DIV + 6) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_tests++; if (scl !== 1'b1 || sda !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_bus: scl %b sda %b expected 1 1", scl, sda);
        end
        n_tests++; if (busy !== 1'b0 || state !== 3'd0 || ack_error !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_state: busy %b state %0d ack_error %b expected 0 0 0", busy, state, ack_error);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(SLV_ADDR, 8'h3C, 1'b1);
        wait_done(dcyc);
        n_tests++; if (dcyc < 0 || dcyc - acc_cyc !== exp_clks(SLV_ADDR)) begin
            n_fail++; $display("FAIL reset_mid_next_latency: got %0d expected %0d", dcyc - acc_cyc, exp_clks(SLV_ADDR));
        end
        n_tests++; if (bus_diff() !== 0 || ack_error !== 1'b0 || rx_data !== 8'h3C) begin
            n_fail++; $display("FAIL reset_mid_next_bus: %0d bit errors, ack_error %b rx %h expected 0 0 3c", bus_diff(), ack_error, rx_data);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        slave_addr  = '0;
        tx_data     = '0;
        data_ack_en = 1'b1;
        test_reset();
        test_write_ack();
        test_addr_nack();
        test_data_nack();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
